// File: rtl/mac_stream_pkg.sv
// Shared types and the reference MAC function for the 3-beat MAC stream initiator.
package mac_stream_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BEAT_A,
    BEAT_B,
    BEAT_C,
    WAIT_RSP,
    GAP
  } state_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
  } triple_t;

  localparam int BEATS = 3;

  // Full-width product and sum, then truncated, so wrap-around matches the receiver.
  function automatic logic [7:0] mac8(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] c);
    logic [15:0] prod;
    logic [16:0] sum;
    prod = 16'(a) * 16'(b);
    sum  = 17'(prod) + 17'(c);
    return 8'(sum);
  endfunction

endpackage

// File: rtl/mac_stream_fifo.sv
// Request FIFO of operand triples; extra pointer bit separates full from empty.
module mac_stream_fifo
  import mac_stream_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  logic    pop,
  input  triple_t din,
  output triple_t dout,
  output logic    full,
  output logic    empty
);

  localparam int AW = $clog2(DEPTH);

  triple_t        mem [DEPTH];
  logic    [AW:0] wr_ptr;
  logic    [AW:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/mac_stream_tx.sv
// Initiator end of the MAC stream: serialises queued triples as three beats and
// checks each receiver result against a locally computed (a*b+c) mod 256.
module mac_stream_tx #(
  parameter int DEPTH   = 4,
  parameter int GAP     = 1,
  parameter int TIMEOUT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  input  logic [7:0] req_c,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic [7:0] rsp_exp,
  output logic       rsp_err,
  output logic       rsp_mismatch,
  output logic       busy
);
  import mac_stream_pkg::*;

  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(GAP + 1);

  state_t          state;
  triple_t         work;
  triple_t         head;
  triple_t         req_triple;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic [WW-1:0]   wait_cnt;
  logic [GW-1:0]   gap_cnt;

  assign req_triple = '{a: req_a, b: req_b, c: req_c};
  assign req_ready  = !full;
  assign push       = req_valid && req_ready;
  assign pop        = (state == IDLE) && !empty;
  assign busy       = (state != IDLE) || !empty;

  mac_stream_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (req_triple),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  // The GAP state is named through the package because the module parameter shadows it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      work         <= '0;
      wait_cnt     <= '0;
      gap_cnt      <= '0;
      tx_valid     <= 1'b0;
      tx_data      <= '0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      rsp_exp      <= '0;
      rsp_err      <= 1'b0;
      rsp_mismatch <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty) begin
            work     <= head;
            rsp_exp  <= mac8(head.a, head.b, head.c);
            tx_valid <= 1'b1;
            tx_data  <= head.a;
            state    <= BEAT_A;
          end
        end
        BEAT_A: begin
          tx_data <= work.b;
          state   <= BEAT_B;
        end
        BEAT_B: begin
          tx_data <= work.c;
          state   <= BEAT_C;
        end
        BEAT_C: begin
          tx_valid <= 1'b0;
          tx_data  <= '0;
          wait_cnt <= '0;
          state    <= WAIT_RSP;
        end
        // A result arriving on the final wait cycle still wins over the timeout.
        WAIT_RSP: begin
          if (rx_valid) begin
            rsp_valid    <= 1'b1;
            rsp_data     <= rx_data;
            rsp_err      <= 1'b0;
            rsp_mismatch <= (rx_data != rsp_exp);
            gap_cnt      <= '0;
            state        <= mac_stream_pkg::GAP;
          end else if (wait_cnt == WW'(TIMEOUT - 1)) begin
            rsp_valid    <= 1'b1;
            rsp_data     <= '0;
            rsp_err      <= 1'b1;
            rsp_mismatch <= 1'b0;
            gap_cnt      <= '0;
            state        <= mac_stream_pkg::GAP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        mac_stream_pkg::GAP: begin
          if (gap_cnt == GW'(GAP - 1)) state <= IDLE;
          else                         gap_cnt <= gap_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_stream_tx.sv
// Self-checking bench for mac_stream_tx: table of triples with a stub receiver,
// plus burst/backpressure and reset-mid-triple sequences, all scoreboard checked.
module tb_mac_stream_tx;
  import mac_stream_pkg::BEATS;

  localparam int DEPTH   = 4;
  localparam int GAP     = 1;
  localparam int TIMEOUT = 4;

  typedef struct {
    logic [7:0] a, b, c;
    int         delay;
    logic [7:0] rdata;
    bit         gap_pulse;
    logic [7:0] exp_data, exp_exp;
    bit         exp_err, exp_mis;
  } vec_t;

  typedef struct {
    logic [7:0] data, exp;
    bit         err, mis;
    int         lat;
  } rsp_t;

  typedef struct {
    int         delay;
    logic [7:0] data;
    bit         gap_pulse;
  } rxcfg_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] req_a = '0, req_b = '0, req_c = '0;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rsp_valid;
  logic [7:0] rsp_data, rsp_exp;
  logic       rsp_err, rsp_mismatch, busy;

  logic [7:0] beat_q[$];
  rsp_t       rsp_q[$];
  rxcfg_t     rx_q[$];
  int         n_vec = 0;
  int         n_mis = 0;
  vec_t       vecs[7];

  mac_stream_tx #(.DEPTH(DEPTH), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_c        (req_c),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_exp      (rsp_exp),
    .rsp_err      (rsp_err),
    .rsp_mismatch (rsp_mismatch),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] model(input int a, input int b, input int c);
    return 8'((a * b + c) % 256);
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_vec++;
    if (actual != expected) begin
      n_mis++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v, output bit stalled);
    int     guard;
    rsp_t   r;
    rxcfg_t x;
    @(negedge clk);
    req_valid = 1'b1;
    req_a = v.a;
    req_b = v.b;
    req_c = v.c;
    stalled = 1'b0;
    guard = 0;
    while (!req_ready && guard < 100) begin
      stalled = 1'b1;
      guard++;
      @(negedge clk);
    end
    if (!req_ready) begin
      checkOutput("push_timeout", 0, 1);
      req_valid = 1'b0;
    end else begin
      beat_q.push_back(v.a);
      beat_q.push_back(v.b);
      beat_q.push_back(v.c);
      r.data = v.exp_data;
      r.exp  = v.exp_exp;
      r.err  = v.exp_err;
      r.mis  = v.exp_mis;
      r.lat  = ((v.delay == 0) ? TIMEOUT : v.delay) + 1;
      rsp_q.push_back(r);
      x.delay     = v.delay;
      x.data      = v.rdata;
      x.gap_pulse = v.gap_pulse;
      rx_q.push_back(x);
      @(posedge clk);
    end
  endtask

  task automatic waitDrain();
    int g;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while ((busy || rsp_q.size() != 0) && g < 300);
    checkOutput("drain", int'(busy || rsp_q.size() != 0), 0);
  endtask

  // Stub receiver: answers in wait cycle 'delay' (0 = silent), optionally pokes rx_valid in GAP.
  initial begin
    int     beats, wcnt;
    bit     active;
    rxcfg_t cur;
    rx_valid = 1'b0;
    rx_data  = '0;
    beats = 0;
    wcnt = 0;
    active = 1'b0;
    cur = '{0, 8'h00, 1'b0};
    forever begin
      @(negedge clk);
      rx_valid = 1'b0;
      if (rst) begin
        beats = 0;
        active = 1'b0;
      end else begin
        if (active) begin
          wcnt++;
          if (cur.delay != 0 && wcnt == cur.delay) begin
            rx_valid = 1'b1;
            rx_data  = cur.data;
          end else if (cur.gap_pulse && cur.delay != 0 && wcnt == cur.delay + 1) begin
            rx_valid = 1'b1;
            rx_data  = 8'hEE;
          end
          if (wcnt > TIMEOUT + 2) active = 1'b0;
        end
        if (tx_valid) begin
          beats++;
          if (beats == BEATS) begin
            beats = 0;
            if (rx_q.size() != 0) cur = rx_q.pop_front();
            else cur = '{0, 8'h00, 1'b0};
            active = 1'b1;
            wcnt = 0;
          end
        end
      end
    end
  end

  // Monitor: beat order/contiguity, inter-triple idle, response fields and latency.
  initial begin
    int         run, idle, since;
    bit         seen;
    rsp_t       e;
    logic [7:0] eb;
    run = 0;
    idle = 0;
    since = -1;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        run = 0;
        idle = 0;
        since = -1;
        seen = 1'b0;
      end else begin
        if (since >= 0) since++;
        if (tx_valid) begin
          if (run == 0 && seen) checkOutput("idle_gap", int'(idle >= GAP + 1), 1);
          run++;
          idle = 0;
          if (beat_q.size() == 0) checkOutput("unexpected_beat", 1, 0);
          else begin
            eb = beat_q.pop_front();
            checkOutput("tx_data", int'(tx_data), int'(eb));
          end
          if (run == BEATS) since = 0;
        end else begin
          if (run != 0) begin
            checkOutput("beat_run", run, BEATS);
            seen = 1'b1;
          end
          run = 0;
          idle++;
        end
        if (rsp_valid) begin
          if (rsp_q.size() == 0) checkOutput("unexpected_rsp", 1, 0);
          else begin
            e = rsp_q.pop_front();
            checkOutput("rsp_data", int'(rsp_data), int'(e.data));
            checkOutput("rsp_exp", int'(rsp_exp), int'(e.exp));
            checkOutput("rsp_err", int'(rsp_err), int'(e.err));
            checkOutput("rsp_mismatch", int'(rsp_mismatch), int'(e.mis));
            checkOutput("rsp_latency", since, e.lat);
          end
          since = -1;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit   st;
    int   g, n_tx, n_rsp;
    vec_t v;
    vec_t rv[3];

    //          a       b       c     dly rdata  gp    data    exp     err   mis
    vecs[0] = '{8'd3,   8'd4,   8'd5,   1, 8'd17,  1'b0, 8'd17,  8'd17,  1'b0, 1'b0};
    vecs[1] = '{8'd20,  8'd20,  8'd100, 1, 8'd244, 1'b0, 8'd244, 8'd244, 1'b0, 1'b0};
    vecs[2] = '{8'd16,  8'd16,  8'd1,   1, 8'd0,   1'b0, 8'd0,   8'd1,   1'b0, 1'b1};
    vecs[3] = '{8'd7,   8'd9,   8'd2,   0, 8'd0,   1'b0, 8'd0,   8'd65,  1'b1, 1'b0};
    vecs[4] = '{8'd255, 8'd255, 8'd255, 4, 8'd0,   1'b0, 8'd0,   8'd0,   1'b0, 1'b0};
    vecs[5] = '{8'd10,  8'd3,   8'd1,   2, 8'd31,  1'b1, 8'd31,  8'd31,  1'b0, 1'b0};
    vecs[6] = '{8'd200, 8'd2,   8'd100, 3, 8'h55,  1'b0, 8'h55,  8'd244, 1'b0, 1'b1};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_tx_valid", int'(tx_valid), 0);
    checkOutput("reset_tx_data", int'(tx_data), 0);
    checkOutput("reset_rsp_valid", int'(rsp_valid), 0);
    checkOutput("reset_rsp_data", int'(rsp_data), 0);
    checkOutput("reset_rsp_exp", int'(rsp_exp), 0);
    checkOutput("reset_rsp_err", int'(rsp_err), 0);
    checkOutput("reset_rsp_mismatch", int'(rsp_mismatch), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_req_ready", int'(req_ready), 1);
    rst = 1'b0;

    // First request on an idle block: first beat two cycles after acceptance.
    applyStimulus(vecs[0], st);
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("first_beat_early", int'(tx_valid), 0);
    @(negedge clk);
    checkOutput("first_beat_valid", int'(tx_valid), 1);
    checkOutput("first_beat_data", int'(tx_data), 3);
    waitDrain();
    checkOutput("rsp_hold", int'(rsp_data), 17);

    for (int i = 1; i < 7; i++) begin
      applyStimulus(vecs[i], st);
      @(negedge clk);
      req_valid = 1'b0;
      waitDrain();
    end

    // Burst: hold the FSM on a slow triple so DEPTH pushes fill the FIFO.
    v = '{8'd1, 8'd2, 8'd3, 4, 8'd5, 1'b0, 8'd5, 8'd5, 1'b0, 1'b0};
    applyStimulus(v, st);
    @(negedge clk);
    req_valid = 1'b0;
    g = 0;
    while (!tx_valid && g < 10) begin
      @(negedge clk);
      g++;
    end
    checkOutput("burst_first_beat", int'(tx_valid), 1);
    for (int k = 0; k <= DEPTH; k++) begin
      v.a = 8'(30 + k * 41);
      v.b = 8'(7 + k * 19);
      v.c = 8'(250 - k * 3);
      v.delay = (k % 2) + 1;
      v.rdata = model(int'(v.a), int'(v.b), int'(v.c));
      v.exp_data = v.rdata;
      v.exp_exp = v.rdata;
      applyStimulus(v, st);
      checkOutput("burst_stall", int'(st), int'(k == DEPTH));
    end
    @(negedge clk);
    req_valid = 1'b0;
    waitDrain();

    // Reset during BEAT_B with two triples still queued.
    for (int k = 0; k < 3; k++) begin
      rv[k] = '{8'(9 + k), 8'd8, 8'd7, 1, model(9 + k, 8, 7), 1'b0,
                model(9 + k, 8, 7), model(9 + k, 8, 7), 1'b0, 1'b0};
      applyStimulus(rv[k], st);
    end
    @(negedge clk);
    req_valid = 1'b0;
    g = 0;
    while (!(tx_valid && tx_data == rv[0].b) && g < 10) begin
      @(negedge clk);
      g++;
    end
    checkOutput("reach_beat_b", int'(tx_valid && tx_data == rv[0].b), 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("midreset_tx_valid", int'(tx_valid), 0);
    checkOutput("midreset_busy", int'(busy), 0);
    checkOutput("midreset_req_ready", int'(req_ready), 1);
    checkOutput("midreset_rsp_valid", int'(rsp_valid), 0);
    beat_q.delete();
    rsp_q.delete();
    rx_q.delete();
    @(negedge clk);
    #2 rst = 1'b0;
    n_tx = 0;
    n_rsp = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx_valid) n_tx++;
      if (rsp_valid) n_rsp++;
    end
    checkOutput("post_reset_tx", n_tx, 0);
    checkOutput("post_reset_rsp", n_rsp, 0);
    checkOutput("post_reset_busy", int'(busy), 0);

    applyStimulus(vecs[1], st);
    @(negedge clk);
    req_valid = 1'b0;
    waitDrain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
